// File: rtl/ctrl_packet_encoder.sv
// ctrl_packet_encoder
// Encodes decoded control commands into 14-bit even-parity packets and queues them in a
// small FIFO for a downstream consumer.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   cmd        - decoded command (control_signal_t)
//   cmd_valid  - cmd is present
//   cmd_ready  - encoder can accept cmd this cycle
//   flush      - discard every queued packet
//   pkt        - encoded packet at the queue head (zero when empty)
//   pkt_valid  - pkt holds a packet
//   pkt_ready  - downstream consumes pkt
//   fifo_level - number of queued packets
//   pkt_count  - packets delivered, wraps at 16 bits
//   drop_count - accepted commands that were discarded, saturates at 255

package ctrl_packet_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_STORE, OP_COMP} op_code_t;
  typedef enum logic [1:0] {COMP_ADD, COMP_MUL, COMP_MAC, COMP_RELU} comp_type_t;

  typedef struct packed {
    logic [1:0] unit_id;
    op_code_t   op_code;
    comp_type_t comp_type;
    logic [3:0] addr;
    logic       valid;
    logic [2:0] size;
  } control_signal_t;

  typedef struct packed {
    logic [5:0] encoded_control;
    logic [7:0] data_control;
  } control_packet_t;

endpackage

module ctrl_packet_encoder
  import ctrl_packet_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  control_signal_t               cmd,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          flush,
  output control_packet_t               pkt,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pkt_count,
  output logic [7:0]                    drop_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  control_packet_t mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [LvlW-1:0] level;

  control_packet_t enc;
  logic            accept;
  logic            push;
  logic            drop;
  logic            pop;

  // Encoding happens on the way in so the FIFO only ever holds finished packets.
  always_comb begin
    enc                      = '0;
    enc.encoded_control      = {cmd.unit_id, cmd.op_code, cmd.comp_type};
    enc.data_control[7:1]    = {cmd.addr, cmd.size};
    // Parity bit makes the whole 14-bit packet even.
    enc.data_control[0]      = ^{cmd.unit_id, cmd.op_code, cmd.comp_type, cmd.addr, cmd.size};
  end

  // Full is judged on the registered level only; a same-cycle pop never frees a slot early.
  assign cmd_ready  = !rst && !flush && (level < LvlW'(FIFO_DEPTH));
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && cmd.valid && (cmd.op_code != OP_NOP);
  assign drop       = accept && !(cmd.valid && (cmd.op_code != OP_NOP));

  assign pkt_valid  = (level != '0);
  assign pop        = pkt_valid && pkt_ready;
  // Gate the head so an empty queue (including right after reset) presents zero.
  assign pkt        = pkt_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  // Storage needs no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
        if (push && !pop) begin
          level <= level + LvlW'(1);
        end else if (pop && !push) begin
          level <= level - LvlW'(1);
        end
      end
      // A pop in the flush cycle is still a delivered packet.
      if (pop) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_packet_encoder.sv
// Self-checking bench for ctrl_packet_encoder: directed steps plus a cycle-level scoreboard.
module tb_ctrl_packet_encoder;
  import ctrl_packet_pkg::*;

  localparam int unsigned Depth = 4;

  logic            clk = 1'b0;
  logic            rst;
  control_signal_t cmd;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            flush;
  control_packet_t pkt;
  logic            pkt_valid;
  logic            pkt_ready;
  logic [2:0]      fifo_level;
  logic [15:0]     pkt_count;
  logic [7:0]      drop_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;

  logic [13:0] q[$];
  int unsigned pc = 0;
  int unsigned dc = 0;

  always #5 clk = ~clk;

  ctrl_packet_encoder #(.FIFO_DEPTH(Depth)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .flush     (flush),
    .pkt       (pkt),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .fifo_level(fifo_level),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: {unit, op, comp, addr, size, p} with even overall parity.
  function automatic logic [13:0] model_enc(input control_signal_t c);
    logic [12:0] body;
    body = {c.unit_id, 2'(c.op_code), 2'(c.comp_type), c.addr, c.size};
    return {body, ^body};
  endfunction

  function automatic control_signal_t mk(input int unsigned i);
    control_signal_t c;
    c.unit_id   = 2'(i);
    c.op_code   = op_code_t'(2'(1 + (i % 3)));
    c.comp_type = comp_type_t'(2'(i >> 1));
    c.addr      = 4'(i * 3 + 1);
    c.valid     = 1'b1;
    c.size      = 3'(i * 5);
    return c;
  endfunction

  // Compare at the negedge against the model, then predict what the next rising edge does.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ready;
      exp_ready = !rst && !flush && (q.size() < Depth);
      chk("fifo_level", 32'(fifo_level), q.size());
      chk("pkt_valid", 32'(pkt_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("pkt_head", 32'(pkt), 32'(q[0]));
      chk("pkt_count", 32'(pkt_count), pc & 32'hFFFF);
      chk("drop_count", 32'(drop_count), dc);
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      if (rst) begin
        q.delete();
        pc = 0;
        dc = 0;
      end else begin
        if (q.size() != 0 && pkt_ready) begin
          void'(q.pop_front());
          pc++;
        end
        if (flush) begin
          q.delete();
        end else if (cmd_valid && exp_ready) begin
          if (cmd.valid && cmd.op_code != OP_NOP) q.push_back(model_enc(cmd));
          else if (dc < 255) dc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && pkt_valid; k++) tick();
    chk("drain_done", 32'(pkt_valid), 32'd0);
  endtask

  initial begin
    control_signal_t c;
    logic [13:0]     head;
    rst = 1'b1; cmd = '0; cmd_valid = 1'b0; flush = 1'b0; pkt_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_pkt", 32'(pkt), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Encode example.
    c = '{unit_id: 2'd1, op_code: OP_COMP, comp_type: COMP_RELU, addr: 4'hA, valid: 1'b1,
          size: 3'b101};
    cmd = c; cmd_valid = 1'b1; pkt_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("enc_valid", 32'(pkt_valid), 32'd1);
    chk("enc_pkt", 32'(pkt), 32'h1FAB);
    tick();
    chk("enc_count", 32'(pkt_count), 32'd1);

    // Drops: NOP then invalid.
    c.op_code = OP_NOP; cmd = c; cmd_valid = 1'b1;
    tick();
    c.op_code = OP_COMP; c.valid = 1'b0; cmd = c;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("drop_count2", 32'(drop_count), 32'd2);
    chk("drop_level", 32'(fifo_level), 32'd0);
    chk("drop_no_pkt", 32'(pkt_valid), 32'd0);

    // Full / backpressure.
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd = mk(i); cmd_valid = 1'b1;
      tick();
    end
    cmd = mk(4);
    #1;
    head = model_enc(mk(0));
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_head", 32'(pkt), 32'(head));
    tick();
    chk("full_stable", 32'(pkt), 32'(head));
    pkt_ready = 1'b1;
    tick();
    chk("after_pop_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    drain();
    chk("full_count", 32'(pkt_count), 32'd6);

    // Simultaneous push/pop at level 2.
    pkt_ready = 1'b0;
    for (int i = 10; i < 12; i++) begin
      cmd = mk(i); cmd_valid = 1'b1;
      tick();
    end
    pkt_ready = 1'b1;
    for (int i = 12; i < 22; i++) begin
      cmd = mk(i);
      tick();
      chk("pushpop_level", 32'(fifo_level), 32'd2);
    end
    cmd_valid = 1'b0;
    drain();
    chk("pushpop_count", 32'(pkt_count), 32'd18);

    // Flush with 3 queued; a pop rides the flush cycle, an offered cmd is refused.
    pkt_ready = 1'b0;
    for (int i = 30; i < 33; i++) begin
      cmd = mk(i); cmd_valid = 1'b1;
      tick();
    end
    cmd = mk(33); flush = 1'b1; pkt_ready = 1'b1;
    #1;
    chk("flush_ready", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_valid", 32'(pkt_valid), 32'd0);
    chk("flush_count", 32'(pkt_count), 32'd19);

    // Reset mid-operation with pkt_count 7 and 3 queued.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 40; i < 47; i++) begin
      cmd = mk(i); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    drain();
    chk("pre_rst_count", 32'(pkt_count), 32'd7);
    pkt_ready = 1'b0;
    for (int i = 50; i < 53; i++) begin
      cmd = mk(i); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
    chk("mid_rst_pkt", 32'(pkt), 32'd0);
    chk("mid_rst_count", 32'(pkt_count), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    pkt_ready = 1'b1;
    #1;
    chk("rel_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    chk("rel_rst_valid", 32'(pkt_valid), 32'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
